multicycle_control_fsm: RTL and testbench

//  Control unit for the 16-bit multi-cycle core; the issuing end of the datapath control interface.

---
 rtl/multicycle_control_fsm.sv | 148 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: control unit for the 16-bit multi-cycle core
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] input_opcode,
  input  logic [2:0] input_funct,
  input  logic       input_Zero,
  input  logic       input_negative,
  input  logic       input_mem_ready,
  output logic [1:0] output_ALUSrcA,
  output logic [1:0] output_ALUSrcB,
  output logic [2:0] output_ALUOp,
  output logic       output_PCSrc,
  output logic       output_PCWrite,
  output logic       output_IRWrite,
  output logic       output_IorD,
  output logic       output_MemRead,
  output logic       output_MemWrite,
  output logic       output_RegWrite,
  output logic       output_MemtoReg,
  output logic       output_halted,
  output logic       output_error,
  output logic [3:0] output_state
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    HALT     = 4'd11,
    ERROR    = 4'd12
  } state_t;
  state_t     state, nxt;
  logic [3:0] op;
  logic [7:0] cnt;
  logic       halted, error;
  logic       mem_wait, timeout;
  // A wait cycle is a memory state without ready; the last allowed one diverts to ERROR
  assign mem_wait = (state == FETCH || state == MEM_RD || state == MEM_WR) && !input_mem_ready;
  assign timeout  = mem_wait && cnt == 8'(MEM_TIMEOUT - 1);
  assign output_state  = state;
  assign output_halted = halted;
  assign output_error  = error;
  // Next-state selection; opcode is taken live in DECODE and the held copy is used afterwards
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = input_mem_ready ? DECODE : timeout ? ERROR : FETCH;
      DECODE:
        case (input_opcode)
          4'h0:                nxt = EXEC_R;
          4'h1:                nxt = EXEC_I;
          4'h2, 4'h3:          nxt = MEM_ADDR;
          4'h4, 4'h5, 4'h6:    nxt = BRANCH;
          4'h7:                nxt = JUMP;
          4'hF:                nxt = HALT;
          default:             nxt = ERROR;
        endcase
      EXEC_R, EXEC_I: nxt = ALU_WB;
      MEM_ADDR: nxt = op == 4'h2 ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = input_mem_ready ? MEM_WB : timeout ? ERROR : MEM_RD;
      MEM_WR:   nxt = input_mem_ready ? FETCH : timeout ? ERROR : MEM_WR;
      ALU_WB, MEM_WB, BRANCH, JUMP: nxt = FETCH;
      default:  nxt = state;
    endcase
  end
  // State, held opcode, wait counter and sticky flags set on entry to HALT/ERROR
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= FETCH;
      op     <= 4'h0;
      cnt    <= 8'd0;
      halted <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= nxt;
      op     <= state == DECODE ? input_opcode : op;
      cnt    <= mem_wait && !timeout ? cnt + 8'd1 : 8'd0;
      halted <= halted | (nxt == HALT);
      error  <= error | (nxt == ERROR);
    end
  // Control decode from state plus ready/flags; everything forced low while in reset
  always_comb begin
    output_ALUSrcA  = 2'd0;
    output_ALUSrcB  = 2'd0;
    output_ALUOp    = 3'd0;
    output_PCSrc    = 1'b0;
    output_PCWrite  = 1'b0;
    output_IRWrite  = 1'b0;
    output_IorD     = 1'b0;
    output_MemRead  = 1'b0;
    output_MemWrite = 1'b0;
    output_RegWrite = 1'b0;
    output_MemtoReg = 1'b0;
    if (reset_n)
      case (state)
        FETCH: begin
          output_MemRead = 1'b1;
          output_ALUSrcB = 2'd1;
          output_IRWrite = input_mem_ready;
          output_PCWrite = input_mem_ready;
        end
        DECODE: output_ALUSrcB = 2'd2;
        EXEC_R: begin
          output_ALUSrcA = 2'd2;
          output_ALUOp   = input_funct;
        end
        EXEC_I, MEM_ADDR: begin
          output_ALUSrcA = 2'd2;
          output_ALUSrcB = 2'd2;
        end
        ALU_WB: output_RegWrite = 1'b1;
        MEM_RD: begin
          output_MemRead = 1'b1;
          output_IorD    = 1'b1;
        end
        MEM_WB: begin
          output_RegWrite = 1'b1;
          output_MemtoReg = 1'b1;
        end
        MEM_WR: begin
          output_MemWrite = 1'b1;
          output_IorD     = 1'b1;
        end
        BRANCH: begin
          output_ALUSrcA = 2'd2;
          output_ALUOp   = 3'd1;
          output_PCSrc   = 1'b1;
          output_PCWrite = (op == 4'h4 && input_Zero) || (op == 4'h5 && !input_Zero) ||
                           (op == 4'h6 && input_negative);
        end
        JUMP: begin
          output_PCSrc   = 1'b1;
          output_PCWrite = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: random instruction stream against a per-instruction cycle-script model
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] input_opcode = 4'h0;
  logic [2:0] input_funct = 3'd0;
  logic       input_Zero = 1'b0, input_negative = 1'b0, input_mem_ready = 1'b0;
  logic [1:0] output_ALUSrcA, output_ALUSrcB;
  logic [2:0] output_ALUOp;
  logic       output_PCSrc, output_PCWrite, output_IRWrite, output_IorD, output_MemRead;
  logic       output_MemWrite, output_RegWrite, output_MemtoReg, output_halted, output_error;
  logic [3:0] output_state;
  int passed = 0, total = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .input_opcode(input_opcode), .input_funct(input_funct),
    .input_Zero(input_Zero), .input_negative(input_negative), .input_mem_ready(input_mem_ready),
    .output_ALUSrcA(output_ALUSrcA), .output_ALUSrcB(output_ALUSrcB), .output_ALUOp(output_ALUOp),
    .output_PCSrc(output_PCSrc), .output_PCWrite(output_PCWrite), .output_IRWrite(output_IRWrite),
    .output_IorD(output_IorD), .output_MemRead(output_MemRead), .output_MemWrite(output_MemWrite),
    .output_RegWrite(output_RegWrite), .output_MemtoReg(output_MemtoReg),
    .output_halted(output_halted), .output_error(output_error), .output_state(output_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Control word: SrcA, SrcB, ALUOp, PCSrc, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg
  function automatic logic [14:0] c(logic [1:0] sa, logic [1:0] sb, logic [2:0] aop, logic pcs,
                                    logic pcw, logic irw, logic iord, logic mr, logic mw,
                                    logic rw, logic m2r);
    return {sa, sb, aop, pcs, pcw, irw, iord, mr, mw, rw, m2r};
  endfunction

  task automatic chk(input logic [3:0] st, input logic [14:0] ctl, input logic h, input logic e,
                     input string tag);
    logic [20:0] obs, exp;
    obs = {output_state, output_ALUSrcA, output_ALUSrcB, output_ALUOp, output_PCSrc, output_PCWrite,
           output_IRWrite, output_IorD, output_MemRead, output_MemWrite, output_RegWrite,
           output_MemtoReg, output_halted, output_error};
    exp = {st, ctl, h, e};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Inputs are set by the caller just after a rising edge; outputs are checked mid-cycle
  task automatic cyc(input logic [3:0] st, input logic [14:0] ctl, input logic h, input logic e,
                     input string tag);
    #3 chk(st, ctl, h, e, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic fetch(input int waits);
    input_mem_ready = 1'b0;
    for (int i = 0; i < waits; i++) cyc(4'd0, c(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, "fetch_wait");
    input_mem_ready = 1'b1;
    cyc(4'd0, c(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0), 0, 0, "fetch");
  endtask

  // One instruction as the sequence of cycles it must take, from opcode rules and wait counts
  task automatic instr(input logic [3:0] opc, input logic [2:0] fn, input logic z, input logic n,
                       input int wf, input int wm);
    logic taken;
    fetch(wf);
    input_opcode = opc;
    input_mem_ready = 1'($urandom);
    cyc(4'd1, c(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "decode");
    input_opcode = 4'($urandom);
    input_funct = fn;
    input_Zero = z;
    input_negative = n;
    input_mem_ready = 1'($urandom);
    case (opc)
      4'h0: begin
        cyc(4'd2, c(2, 0, fn, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "exec_r");
        cyc(4'd8, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, "alu_wb_r");
      end
      4'h1: begin
        cyc(4'd3, c(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "exec_i");
        cyc(4'd8, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, "alu_wb_i");
      end
      4'h2, 4'h3: begin
        cyc(4'd4, c(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "mem_addr");
        input_mem_ready = 1'b0;
        for (int i = 0; i <= wm; i++) begin
          input_mem_ready = i == wm;
          if (opc == 4'h2) cyc(4'd5, c(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0, 0, "mem_rd");
          else cyc(4'd7, c(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), 0, 0, "mem_wr");
        end
        if (opc == 4'h2) cyc(4'd6, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 0, 0, "mem_wb");
      end
      4'h4, 4'h5, 4'h6: begin
        taken = opc == 4'h4 ? z : opc == 4'h5 ? !z : n;
        cyc(4'd9, c(2, 0, 1, 1, taken, 0, 0, 0, 0, 0, 0), 0, 0, "branch");
      end
      default: cyc(4'd10, c(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 0, 0, "jump");
    endcase
  endtask

  initial begin
    #1 chk(4'd0, 15'd0, 0, 0, "reset_initial");
    @(posedge clk);
    #1 reset_n = 1'b1;
    instr(4'h0, 3'd1, 0, 0, 0, 0);
    instr(4'h2, 3'd0, 0, 0, 0, 3);
    instr(4'h4, 3'd0, 1, 0, 0, 0);
    instr(4'h4, 3'd0, 0, 0, 0, 0);
    instr(4'h6, 3'd0, 0, 1, 0, 0);
    instr(4'h5, 3'd0, 0, 0, 1, 0);
    for (int k = 0; k < 60; k++)
      instr(4'($urandom_range(0, 7)), 3'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4), $urandom_range(0, 4));
    fetch(0);
    input_opcode = 4'h2;
    cyc(4'd1, c(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "decode_lw");
    cyc(4'd4, c(2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "mem_addr_lw");
    input_mem_ready = 1'b0;
    cyc(4'd5, c(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0, 0, "mem_rd_before_reset");
    input_mem_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk(4'd0, 15'd0, 0, 0, "async_reset_mid_mem_rd");
    @(posedge clk);
    #1 chk(4'd0, 15'd0, 0, 0, "held_in_reset");
    reset_n = 1'b1;
    input_mem_ready = 1'b0;
    cyc(4'd0, c(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, "fetch_after_release");
    fetch(0);
    input_opcode = 4'hA;
    cyc(4'd1, c(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "decode_illegal");
    for (int i = 0; i < 5; i++) begin
      input_opcode = 4'($urandom);
      input_mem_ready = 1'($urandom);
      input_Zero = 1'($urandom);
      cyc(4'd12, 15'd0, 0, 1, "error_hold");
    end
    do_reset();
    input_mem_ready = 1'b0;
    cyc(4'd0, c(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, "error_cleared");
    fetch(0);
    input_opcode = 4'hF;
    cyc(4'd1, c(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "decode_halt");
    for (int i = 0; i < 3; i++) begin
      input_mem_ready = 1'($urandom);
      cyc(4'd11, 15'd0, 1, 0, "halt_hold");
    end
    do_reset();
    input_mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc(4'd0, c(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, "timeout_wait");
    cyc(4'd12, 15'd0, 0, 1, "timeout_error");
    do_reset();
    fetch(14);
    cyc(4'd1, c(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "ready_on_last_wait");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
